// File: rtl/hdlc_chk_pkg.sv
// Shared identifiers, bit patterns and helpers for the HDLC protocol monitor.
package hdlc_chk_pkg;

    typedef enum logic [2:0] {
        CHK_FLAG,
        CHK_ABORT,
        CHK_ABSIG,
        CHK_IDLE,
        CHK_TXABORT
    } chk_id_e;

    localparam int         NUM_CHK        = 5;
    localparam logic [7:0] FLAG_PAT       = 8'h7E;
    localparam logic [7:0] ABORT_PAT      = 8'h7F;
    localparam logic [2:0] ADDR_TXSC      = 3'd0;
    localparam int         TXSC_ABORT_BIT = 2;

    function automatic int popCnt(input logic [NUM_CHK-1:0] v);
        int n = 0;
        for (int i = 0; i < NUM_CHK; i++) n += int'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/hdlc_chk_delay.sv
// Expectation shift line: a trigger entering now emerges as ExpNow LAT cycles later.
module hdlc_chk_delay #(
    parameter int LAT = 1
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Trig,
    output logic ExpNow
);

    logic [LAT-1:0] vldPipe;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            vldPipe <= '0;
        end else begin
            vldPipe[0] <= Trig;
            for (int i = 1; i < LAT; i++) vldPipe[i] <= vldPipe[i-1];
        end
    end

    assign ExpNow = vldPipe[LAT-1];

endmodule

// File: rtl/hdlc_protocol_monitor.sv
// Passive HDLC checker: bit-level reference of flag/abort/idle/Tx-abort behaviour
// with per-check error pulses, sticky flags and saturating counters.
module hdlc_protocol_monitor
    import hdlc_chk_pkg::*;
#(
    parameter int                 FLAG_LAT    = 2,
    parameter int                 ABORT_LAT   = 2,
    parameter int                 TXABORT_LAT = 3,
    parameter int                 IDLE_LEN    = 8,
    parameter int                 CNT_W       = 16,
    parameter logic [NUM_CHK-1:0] CHK_EN      = 5'h1F
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic                            Clr,
    input  logic                            Rx,
    input  logic                            Rx_FlagDetect,
    input  logic                            Rx_AbortDetect,
    input  logic                            Rx_ValidFrame,
    input  logic                            Rx_AbortSignal,
    input  logic                            Tx,
    input  logic                            Tx_ValidFrame,
    input  logic                            WriteEnable,
    input  logic [2:0]                      Address,
    input  logic [7:0]                      Data_In,
    input  logic                            Tx_AbortedTrans,
    output logic [NUM_CHK-1:0]              ErrPulse,
    output logic [NUM_CHK-1:0]              ErrSticky,
    output logic [NUM_CHK-1:0][CNT_W-1:0]   ErrCnt,
    output logic [CNT_W-1:0]                ErrTotal
);

    localparam int               RUN_W    = $clog2(IDLE_LEN + 2);
    localparam logic [RUN_W-1:0] IDLE_MAX = RUN_W'(IDLE_LEN + 1);

    logic [7:0]                      hist;
    logic [3:0]                      sampCnt;
    logic                            histOk;
    logic [RUN_W-1:0]                idleRun;
    logic                            abortDetQ;
    logic [NUM_CHK-1:0]              trig, expNow, errNow;
    logic [NUM_CHK-1:0][CNT_W-1:0]   cntNext;
    logic [CNT_W-1:0]                cntBase, totBase;
    logic [CNT_W:0]                  totSum;
    logic                            unusedData;

    assign unusedData = ^{Data_In[7:3], Data_In[1:0]};
    assign histOk     = (sampCnt == 4'd8);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            hist      <= '0;
            sampCnt   <= '0;
            idleRun   <= '0;
            abortDetQ <= 1'b0;
        end else begin
            hist      <= {hist[6:0], Rx};
            abortDetQ <= Rx_AbortDetect;
            if (!histOk) sampCnt <= sampCnt + 4'd1;
            if (Tx_ValidFrame)          idleRun <= '0;
            else if (idleRun != IDLE_MAX) idleRun <= idleRun + 1'b1;
        end
    end

    always_comb begin
        trig = '0;
        trig[CHK_FLAG]    = histOk && (hist == FLAG_PAT);
        trig[CHK_ABORT]   = histOk && (hist == ABORT_PAT);
        trig[CHK_ABSIG]   = Rx_AbortDetect && Rx_ValidFrame;
        trig[CHK_IDLE]    = (idleRun == IDLE_MAX);
        trig[CHK_TXABORT] = WriteEnable && (Address == ADDR_TXSC) && Data_In[TXSC_ABORT_BIT];
    end

    for (genvar k = 0; k < NUM_CHK; k++) begin : gChk
        localparam int LAT = (k == int'(CHK_FLAG))    ? FLAG_LAT    :
                             (k == int'(CHK_ABORT))   ? ABORT_LAT   :
                             (k == int'(CHK_TXABORT)) ? TXABORT_LAT : 1;
        hdlc_chk_delay #(.LAT(LAT)) uDelay (
            .Clk    (Clk),
            .Rst    (Rst),
            .Trig   (trig[k] && CHK_EN[k]),
            .ExpNow (expNow[k])
        );
    end

    // Abort must be a genuine rise: low one cycle before the due cycle, high on it.
    always_comb begin
        errNow = '0;
        errNow[CHK_FLAG]    = expNow[CHK_FLAG]    && !Rx_FlagDetect;
        errNow[CHK_ABORT]   = expNow[CHK_ABORT]   && !(Rx_AbortDetect && !abortDetQ);
        errNow[CHK_ABSIG]   = expNow[CHK_ABSIG]   && !Rx_AbortSignal;
        errNow[CHK_IDLE]    = expNow[CHK_IDLE]    && !Tx;
        errNow[CHK_TXABORT] = expNow[CHK_TXABORT] && !Tx_AbortedTrans;
    end

    // Clear takes effect before the same-cycle failure is counted.
    always_comb begin
        cntNext = '0;
        cntBase = '0;
        for (int k = 0; k < NUM_CHK; k++) begin
            cntBase    = Clr ? '0 : ErrCnt[k];
            cntNext[k] = (errNow[k] && (cntBase != '1)) ? cntBase + 1'b1 : cntBase;
        end
        totBase = Clr ? '0 : ErrTotal;
        totSum  = {1'b0, totBase} + (CNT_W+1)'(popCnt(errNow));
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ErrPulse  <= '0;
            ErrSticky <= '0;
            ErrCnt    <= '0;
            ErrTotal  <= '0;
        end else begin
            ErrPulse  <= errNow;
            ErrSticky <= (Clr ? '0 : ErrSticky) | errNow;
            ErrCnt    <= cntNext;
            ErrTotal  <= totSum[CNT_W] ? '1 : totSum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_hdlc_protocol_monitor.sv
// Randomised and directed bench for hdlc_protocol_monitor against a per-cycle history model.
module tb_hdlc_protocol_monitor;
    import hdlc_chk_pkg::*;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic Clk, Rst, Clr, Rx, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_AbortSignal;
    logic Tx, Tx_ValidFrame, WriteEnable, Tx_AbortedTrans;
    logic [2:0] Address;
    logic [7:0] Data_In;
    logic [NUM_CHK-1:0] ErrPulse, ErrSticky;
    logic [NUM_CHK-1:0][CW-1:0] ErrCnt;
    logic [CW-1:0] ErrTotal;

    hdlc_protocol_monitor #(.CNT_W(CW)) dut (
        .Clk(Clk), .Rst(Rst), .Clr(Clr), .Rx(Rx), .Rx_FlagDetect(Rx_FlagDetect),
        .Rx_AbortDetect(Rx_AbortDetect), .Rx_ValidFrame(Rx_ValidFrame),
        .Rx_AbortSignal(Rx_AbortSignal), .Tx(Tx), .Tx_ValidFrame(Tx_ValidFrame),
        .WriteEnable(WriteEnable), .Address(Address), .Data_In(Data_In),
        .Tx_AbortedTrans(Tx_AbortedTrans), .ErrPulse(ErrPulse), .ErrSticky(ErrSticky),
        .ErrCnt(ErrCnt), .ErrTotal(ErrTotal)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Inputs recorded per cycle since reset release (cycle 1 = first sampled cycle).
    bit rxA[4096], fdA[4096], adA[4096], vfA[4096], asA[4096];
    bit txA[4096], tvfA[4096], weA[4096], atA[4096];
    bit [2:0] adrA[4096];
    bit [7:0] dA[4096];
    int cyc, checks, errors, expTot;
    int expCnt[NUM_CHK];
    logic [NUM_CHK-1:0] expPulse, expSticky;

    function automatic logic [7:0] rxByte(int t);
        logic [7:0] h = '0;
        for (int i = 8; i >= 1; i--) h = {h[6:0], rxA[t-i]};
        return h;
    endfunction

    // Which rules fail when evaluated in cycle e, from the recorded input history.
    function automatic logic [NUM_CHK-1:0] expErr(int e);
        logic [NUM_CHK-1:0] r = '0;
        int t;
        bit idle;
        t = e - 2;
        if (t >= 9 && rxByte(t) == 8'h7E && !fdA[e]) r[0] = 1'b1;
        if (t >= 9 && rxByte(t) == 8'h7F && !(adA[e] && !adA[e-1])) r[1] = 1'b1;
        t = e - 1;
        if (t >= 1 && adA[t] && vfA[t] && !asA[e]) r[2] = 1'b1;
        if (t - 9 >= 1) begin
            idle = 1'b1;
            for (int j = t - 9; j < t; j++) if (tvfA[j]) idle = 1'b0;
            if (idle && !txA[e]) r[3] = 1'b1;
        end
        t = e - 3;
        if (t >= 1 && weA[t] && adrA[t] == 3'd0 && dA[t][2] && !atA[e]) r[4] = 1'b1;
        return r;
    endfunction

    task automatic quiet();
        Clr = 0; Rx = 0; Rx_FlagDetect = 0; Rx_AbortDetect = 0; Rx_ValidFrame = 0;
        Rx_AbortSignal = 0; Tx = 1; Tx_ValidFrame = 0; WriteEnable = 0; Address = 0;
        Data_In = 0; Tx_AbortedTrans = 0;
    endtask

    task automatic modelClear();
        for (int k = 0; k < NUM_CHK; k++) expCnt[k] = 0;
        expSticky = '0; expTot = 0; expPulse = '0;
    endtask

    task automatic step();
        logic [NUM_CHK-1:0] p;
        int pc = 0;
        rxA[cyc] = Rx; fdA[cyc] = Rx_FlagDetect; adA[cyc] = Rx_AbortDetect;
        vfA[cyc] = Rx_ValidFrame; asA[cyc] = Rx_AbortSignal; txA[cyc] = Tx;
        tvfA[cyc] = Tx_ValidFrame; weA[cyc] = WriteEnable; adrA[cyc] = Address;
        dA[cyc] = Data_In; atA[cyc] = Tx_AbortedTrans;
        p = expErr(cyc);
        if (Clr) modelClear();
        for (int k = 0; k < NUM_CHK; k++)
            if (p[k]) begin pc++; if (expCnt[k] < CMAX) expCnt[k]++; end
        expSticky |= p;
        expTot = (expTot + pc > CMAX) ? CMAX : expTot + pc;
        @(posedge Clk); cyc++; @(negedge Clk);
        expPulse = p;
    endtask

    task automatic test_reset();
        quiet(); Rst = 0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (ErrPulse !== '0 || ErrSticky !== '0 || ErrCnt !== '0 || ErrTotal !== '0) begin
            errors++;
            $display("FAIL reset_state got p=%b s=%b c=%h t=%h want all 0", ErrPulse, ErrSticky, ErrCnt, ErrTotal);
        end
        Rst = 1; cyc = 1; modelClear();
        for (int i = 0; i < 12; i++) begin
            step(); checks++;
            if (ErrPulse !== expPulse) begin errors++; $display("FAIL reset_quiet cyc=%0d got=%b want=%b", cyc, ErrPulse, expPulse); end
        end
    endtask

    task automatic test_flag();
        logic [7:0] pat = 8'b01111110;
        int hits;
        quiet(); Clr = 1; step(); Clr = 0;
        for (int pass = 0; pass < 2; pass++) begin
            hits = 0;
            for (int i = 0; i < 16; i++) begin
                quiet();
                if (i < 8) Rx = pat[7-i];
                Rx_FlagDetect = (i == (pass == 0 ? 10 : 11));
                step(); checks++;
                hits += int'(ErrPulse[0]);
                if (ErrPulse !== expPulse) begin errors++; $display("FAIL flag_pulse pass=%0d i=%0d got=%b want=%b", pass, i, ErrPulse, expPulse); end
            end
            checks++;
            if (hits != pass || ErrCnt[0] !== CW'(pass)) begin
                errors++; $display("FAIL flag_count pass=%0d got hits=%0d cnt=%0d want %0d", pass, hits, ErrCnt[0], pass);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] seq = 15'b011111101111110;
        int hits = 0;
        for (int i = 0; i < 20; i++) begin
            quiet();
            if (i < 15) Rx = seq[14-i];
            step(); checks++;
            hits += int'(ErrPulse[0]);
            if (ErrPulse !== expPulse) begin errors++; $display("FAIL b2b_pulse i=%0d got=%b want=%b", i, ErrPulse, expPulse); end
        end
        checks++;
        if (hits != 2) begin errors++; $display("FAIL b2b_flags got=%0d want=2", hits); end
    endtask

    task automatic test_abort();
        int hits;
        for (int pass = 0; pass < 2; pass++) begin
            hits = 0;
            for (int i = 0; i < 14; i++) begin
                quiet();
                Rx = (i >= 1 && i <= 7);
                Rx_AbortDetect = (pass == 0) ? (i <= 11) : (i == 10);
                step(); checks++;
                hits += int'(ErrPulse[1]);
                if (ErrPulse !== expPulse) begin errors++; $display("FAIL abort_pulse pass=%0d i=%0d got=%b want=%b", pass, i, ErrPulse, expPulse); end
            end
            checks++;
            if (hits != 1 - pass) begin errors++; $display("FAIL abort_count pass=%0d got=%0d want=%0d", pass, hits, 1 - pass); end
        end
    endtask

    task automatic test_absig();
        for (int i = 0; i < 6; i++) begin
            quiet();
            Rx_AbortDetect = (i == 2); Rx_ValidFrame = (i == 2);
            step(); checks++;
            if (ErrPulse !== expPulse || (i == 3 && ErrPulse[2] !== 1'b1)) begin
                errors++; $display("FAIL absig_pulse i=%0d got=%b want=%b", i, ErrPulse, expPulse);
            end
        end
        checks++;
        if (ErrSticky[2] !== 1'b1 || ErrSticky !== expSticky) begin
            errors++; $display("FAIL absig_sticky got=%b want=%b", ErrSticky, expSticky);
        end
    endtask

    task automatic test_idle();
        int hits;
        for (int pass = 0; pass < 2; pass++) begin
            hits = 0;
            for (int i = 0; i < 16; i++) begin
                quiet();
                Tx_ValidFrame = (i <= 2) || (pass == 1 && i == 8);
                Tx = (i != 13);
                step(); checks++;
                hits += int'(ErrPulse[3]);
                if (ErrPulse !== expPulse) begin errors++; $display("FAIL idle_pulse pass=%0d i=%0d got=%b want=%b", pass, i, ErrPulse, expPulse); end
            end
            checks++;
            if (hits != 1 - pass) begin errors++; $display("FAIL idle_count pass=%0d got=%0d want=%0d", pass, hits, 1 - pass); end
        end
    endtask

    task automatic test_txabort();
        int hits;
        for (int pass = 0; pass < 2; pass++) begin
            hits = 0;
            for (int i = 0; i < 8; i++) begin
                quiet();
                if (i == 1) begin WriteEnable = 1; Address = 3'd0; Data_In = 8'h04; end
                Tx_AbortedTrans = (pass == 0 && i == 4);
                step(); checks++;
                hits += int'(ErrPulse[4]);
                if (ErrPulse !== expPulse) begin errors++; $display("FAIL txab_pulse pass=%0d i=%0d got=%b want=%b", pass, i, ErrPulse, expPulse); end
            end
            checks++;
            if (hits != pass) begin errors++; $display("FAIL txab_count pass=%0d got=%0d want=%0d", pass, hits, pass); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            Clr = ($urandom_range(0, 63) == 0);
            Rx = ($urandom_range(0, 3) != 0);
            Rx_FlagDetect = $urandom_range(0, 1);
            Rx_AbortDetect = ($urandom_range(0, 3) == 0);
            Rx_ValidFrame = $urandom_range(0, 1);
            Rx_AbortSignal = $urandom_range(0, 1);
            Tx = ($urandom_range(0, 9) != 0);
            Tx_ValidFrame = ($urandom_range(0, 15) == 0);
            WriteEnable = ($urandom_range(0, 7) == 0);
            Address = 3'($urandom_range(0, 1));
            Data_In = 8'($urandom);
            Tx_AbortedTrans = $urandom_range(0, 1);
            step(); checks++;
            if (ErrPulse !== expPulse) begin errors++; $display("FAIL rand_pulse i=%0d got=%b want=%b", i, ErrPulse, expPulse); end
        end
        quiet();
        for (int k = 0; k < NUM_CHK; k++) begin
            checks++;
            if (ErrCnt[k] !== CW'(expCnt[k])) begin errors++; $display("FAIL rand_cnt k=%0d got=%0d want=%0d", k, ErrCnt[k], expCnt[k]); end
        end
        checks++;
        if (ErrSticky !== expSticky || ErrTotal !== CW'(expTot)) begin
            errors++; $display("FAIL rand_sum got s=%b t=%0d want s=%b t=%0d", ErrSticky, ErrTotal, expSticky, expTot);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] pat = 8'b01111110;
        quiet(); Clr = 1; step(); Clr = 0;
        for (int i = 0; i < 164; i++) begin
            quiet();
            if (i < 160) Rx = pat[7 - (i % 8)];
            step(); checks++;
            if (ErrPulse !== expPulse) begin errors++; $display("FAIL sat_pulse i=%0d got=%b want=%b", i, ErrPulse, expPulse); end
        end
        checks++;
        if (ErrCnt[0] !== 4'hF || ErrTotal !== 4'hF) begin errors++; $display("FAIL sat_cnt got c=%0d t=%0d want 15", ErrCnt[0], ErrTotal); end
        for (int i = 0; i < 11; i++) begin
            quiet();
            if (i < 8) Rx = pat[7-i];
            Clr = (i == 10);
            step();
        end
        checks++;
        if (ErrCnt[0] !== 4'd1 || ErrSticky[0] !== 1'b1 || ErrTotal !== 4'd1) begin
            errors++; $display("FAIL clr_same_cycle got c=%0d s=%b t=%0d want c=1 s=1 t=1", ErrCnt[0], ErrSticky[0], ErrTotal);
        end
    endtask

    task automatic test_reset_midpipe();
        quiet(); WriteEnable = 1; Data_In = 8'h04; step();
        quiet(); step();
        Rst = 0;
        repeat (2) @(negedge Clk);
        Rst = 1; cyc = 1; modelClear();
        for (int i = 0; i < 8; i++) begin
            step(); checks++;
            if (ErrPulse !== '0 || ErrPulse !== expPulse) begin errors++; $display("FAIL midrst_pulse i=%0d got=%b want=%b", i, ErrPulse, expPulse); end
        end
        checks++;
        if (ErrCnt !== '0 || ErrTotal !== '0) begin errors++; $display("FAIL midrst_cnt got c=%h t=%0d want 0", ErrCnt, ErrTotal); end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 1;
        modelClear();
        test_reset();
        test_flag();
        test_back_to_back();
        test_abort();
        test_absig();
        test_idle();
        test_txabort();
        test_random();
        test_saturation();
        test_reset_midpipe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
